// File: rtl/en_pkg.sv
// Shared types and constants for the enemy-wave block: FSM encoding, sprite colours, missile box size.
package en_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        RUN,
        CLEAR,
        LANDED
    } en_state_t;

    localparam logic [11:0] EN_COLOR         = 12'hF_0_0;
    localparam logic [11:0] EN_MISSILE_COLOR = 12'hF_F_0;

    localparam int MSL_W = 2;
    localparam int MSL_H = 8;

endpackage

// File: rtl/en_wave_draw.sv
// Overlays the enemy row and the enemy missile onto the pixel stream.
// Latency 2 pclk for every output (stage 1 box hits, stage 2 colour mux); no backpressure.
module en_wave_draw
    import en_pkg::*;
#(
    parameter int N       = 4,
    parameter int SPACING = 48,
    parameter int EN_W    = 32,
    parameter int EN_H    = 24
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [10:0]   vcount_in,
    input  logic [10:0]   hcount_in,
    input  logic          vsync_in,
    input  logic          vblnk_in,
    input  logic          hsync_in,
    input  logic          hblnk_in,
    input  logic [11:0]   rgb_in,
    input  logic [10:0]   base_x,
    input  logic [10:0]   base_y,
    input  logic [N-1:0]  alive,
    input  logic [10:0]   msl_x,
    input  logic [10:0]   msl_y,
    input  logic          msl_on,
    output logic [10:0]   vcount_out,
    output logic [10:0]   hcount_out,
    output logic          vsync_out,
    output logic          vblnk_out,
    output logic          hsync_out,
    output logic          hblnk_out,
    output logic [11:0]   rgb_out
);

    logic        en_pix;
    logic        msl_pix;
    logic [10:0] s1_vcount;
    logic [10:0] s1_hcount;
    logic        s1_vsync;
    logic        s1_vblnk;
    logic        s1_hsync;
    logic        s1_hblnk;
    logic [11:0] s1_rgb;
    logic        s1_en;
    logic        s1_msl;

    always_comb begin
        en_pix = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (alive[i] &&
                hcount_in >= base_x + 11'(i * SPACING) &&
                hcount_in <  base_x + 11'(i * SPACING + EN_W) &&
                vcount_in >= base_y &&
                vcount_in <  base_y + 11'(EN_H))
                en_pix = 1'b1;
        end
        msl_pix = msl_on &&
                  hcount_in >= msl_x && hcount_in < msl_x + 11'(MSL_W) &&
                  vcount_in >= msl_y && vcount_in < msl_y + 11'(MSL_H);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            s1_vcount  <= '0;
            s1_hcount  <= '0;
            s1_vsync   <= 1'b0;
            s1_vblnk   <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_hblnk   <= 1'b0;
            s1_rgb     <= '0;
            s1_en      <= 1'b0;
            s1_msl     <= 1'b0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            s1_vcount  <= vcount_in;
            s1_hcount  <= hcount_in;
            s1_vsync   <= vsync_in;
            s1_vblnk   <= vblnk_in;
            s1_hsync   <= hsync_in;
            s1_hblnk   <= hblnk_in;
            s1_rgb     <= rgb_in;
            s1_en      <= en_pix;
            s1_msl     <= msl_pix;
            vcount_out <= s1_vcount;
            hcount_out <= s1_hcount;
            vsync_out  <= s1_vsync;
            vblnk_out  <= s1_vblnk;
            hsync_out  <= s1_hsync;
            hblnk_out  <= s1_hblnk;
            // enemies win over the missile where they overlap
            rgb_out    <= s1_en  ? EN_COLOR :
                          s1_msl ? EN_MISSILE_COLOR : s1_rgb;
        end
    end

endmodule

// File: rtl/en_wave.sv
// Enemy formation: per-frame motion, player-missile collision, round-robin enemy missile (EN_WAVE_MISSILE_EN).
// Pixel path latency 2 pclk, collision 1 pclk, motion 1 pclk after the frame tick; no backpressure.
module en_wave
    import en_pkg::*;
#(
    parameter int N        = 4,
    parameter int X_START  = 64,
    parameter int Y_START  = 48,
    parameter int SPACING  = 48,
    parameter int EN_W     = 32,
    parameter int EN_H     = 24,
    parameter int X_MIN    = 16,
    parameter int X_MAX    = 784,
    parameter int DROP     = 16,
    parameter int Y_LIMIT  = 520,
    parameter int M_SPEED  = 4,
    parameter int SCREEN_H = 600
) (
    input  logic          pclk,
    input  logic          rst,
    input  logic [10:0]   vcount_in,
    input  logic [10:0]   hcount_in,
    input  logic          vsync_in,
    input  logic          vblnk_in,
    input  logic          hsync_in,
    input  logic          hblnk_in,
    input  logic [11:0]   rgb_in,
    input  logic [4:0]    level,
    input  logic          start,
    input  logic [10:0]   xpos_missile,
    input  logic [10:0]   ypos_missile,
    input  logic          on_missile,
    output logic [10:0]   vcount_out,
    output logic [10:0]   hcount_out,
    output logic          vsync_out,
    output logic          vblnk_out,
    output logic          hsync_out,
    output logic          hblnk_out,
    output logic [11:0]   rgb_out,
    output logic [N-1:0]  alive,
    output logic          kill,
    output logic [3:0]    hit_slot,
    output logic          wave_clear,
    output logic          wave_landed,
    output logic [10:0]   xpos_en_missile,
    output logic [10:0]   ypos_en_missile,
    output logic          on_en_missile
);

    localparam int SPAN = (N - 1) * SPACING + EN_W;

    en_state_t   state;
    logic [10:0] base_x;
    logic [10:0] base_y;
    logic        dir_left;
    logic        vblnk_d;
    logic        tick;
    logic [10:0] step;
    logic        bump_right;
    logic        bump_left;
    logic [N-1:0] hit_vec;
    logic [N-1:0] hit_onehot;
    logic [3:0]  hit_idx;
    logic        level_unused;

    assign level_unused = ^level[1:0];
    assign step         = 11'd1 + 11'(level[4:2]);
    // bounds are compared before stepping so the 11-bit position never wraps
    assign bump_right   = (base_x + 11'(SPAN) + step) > 11'(X_MAX);
    assign bump_left    = base_x < (11'(X_MIN) + step);

    always_comb begin
        hit_vec    = '0;
        hit_onehot = '0;
        hit_idx    = '0;
        for (int i = 0; i < N; i++) begin
            hit_vec[i] = alive[i] && on_missile &&
                         xpos_missile >= base_x + 11'(i * SPACING) &&
                         xpos_missile <  base_x + 11'(i * SPACING + EN_W) &&
                         ypos_missile >= base_y &&
                         ypos_missile <  base_y + 11'(EN_H);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_idx       = 4'(i);
            end
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            vblnk_d <= 1'b0;
            tick    <= 1'b0;
        end else begin
            vblnk_d <= vblnk_in;
            tick    <= vblnk_in & ~vblnk_d;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            base_x      <= '0;
            base_y      <= '0;
            dir_left    <= 1'b0;
            alive       <= '0;
            kill        <= 1'b0;
            hit_slot    <= '0;
            wave_clear  <= 1'b0;
            wave_landed <= 1'b0;
        end else begin
            kill        <= 1'b0;
            wave_clear  <= (state == CLEAR);
            wave_landed <= (state == LANDED);
            if (start) begin
                state <= SPAWN;
            end else begin
                case (state)
                    SPAWN: begin
                        alive    <= '1;
                        base_x   <= 11'(X_START);
                        base_y   <= 11'(Y_START);
                        dir_left <= 1'b0;
                        state    <= RUN;
                    end
                    RUN: begin
                        if (alive == '0) begin
                            state <= CLEAR;
                        end else if (base_y >= 11'(Y_LIMIT)) begin
                            state <= LANDED;
                        end else begin
                            if (|hit_vec) begin
                                alive    <= alive & ~hit_onehot;
                                kill     <= 1'b1;
                                hit_slot <= hit_idx;
                            end
                            if (tick) begin
                                if (dir_left ? bump_left : bump_right) begin
                                    base_y   <= base_y + 11'(DROP);
                                    dir_left <= ~dir_left;
                                end else if (dir_left) begin
                                    base_x <= base_x - step;
                                end else begin
                                    base_x <= base_x + step;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef EN_WAVE_MISSILE_EN
    logic [3:0]  rr_ptr;
    logic [10:0] msl_x;
    logic [10:0] msl_y;
    logic        msl_on;
    logic        fire_hi_found;
    logic [3:0]  fire_hi;
    logic [3:0]  fire_lo;
    logic [3:0]  fire_slot;

    // first alive slot at or above rr_ptr, else the lowest alive slot (wrap)
    always_comb begin
        fire_hi_found = 1'b0;
        fire_hi       = '0;
        fire_lo       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (alive[i]) begin
                fire_lo = 4'(i);
                if (4'(i) >= rr_ptr) begin
                    fire_hi_found = 1'b1;
                    fire_hi       = 4'(i);
                end
            end
        end
        fire_slot = fire_hi_found ? fire_hi : fire_lo;
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            msl_x  <= '0;
            msl_y  <= '0;
            msl_on <= 1'b0;
        end else if (state == SPAWN) begin
            msl_on <= 1'b0;
        end else if (state == RUN && tick) begin
            if (msl_on) begin
                msl_y <= msl_y + 11'(M_SPEED);
                if (msl_y + 11'(M_SPEED) >= 11'(SCREEN_H))
                    msl_on <= 1'b0;
            end else if (|alive) begin
                msl_x  <= base_x + 11'(int'(fire_slot) * SPACING + EN_W / 2);
                msl_y  <= base_y + 11'(EN_H);
                msl_on <= 1'b1;
                rr_ptr <= (fire_slot == 4'(N - 1)) ? 4'd0 : fire_slot + 4'd1;
            end
        end
    end

    assign xpos_en_missile = msl_x;
    assign ypos_en_missile = msl_y;
    assign on_en_missile   = msl_on;
`else
    assign xpos_en_missile = '0;
    assign ypos_en_missile = '0;
    assign on_en_missile   = 1'b0;
`endif

    en_wave_draw #(
        .N       (N),
        .SPACING (SPACING),
        .EN_W    (EN_W),
        .EN_H    (EN_H)
    ) u_draw (
        .pclk       (pclk),
        .rst        (rst),
        .vcount_in  (vcount_in),
        .hcount_in  (hcount_in),
        .vsync_in   (vsync_in),
        .vblnk_in   (vblnk_in),
        .hsync_in   (hsync_in),
        .hblnk_in   (hblnk_in),
        .rgb_in     (rgb_in),
        .base_x     (base_x),
        .base_y     (base_y),
        .alive      (alive),
        .msl_x      (xpos_en_missile),
        .msl_y      (ypos_en_missile),
        .msl_on     (on_en_missile),
        .vcount_out (vcount_out),
        .hcount_out (hcount_out),
        .vsync_out  (vsync_out),
        .vblnk_out  (vblnk_out),
        .hsync_out  (hsync_out),
        .hblnk_out  (hblnk_out),
        .rgb_out    (rgb_out)
    );

endmodule

// File: doc/en_wave.md
# en_wave

Parametrised enemy-wave block: a formation of `N` enemies in one row, replacing the single-enemy chain. Per frame it moves the formation, clears enemies hit by the player missile and fires one shared enemy missile from alive enemies in round-robin order. On the pixel path it overlays enemies and the enemy missile onto `rgb_in`. It sits in the VGA pixel chain between background/player drawing and the HUD stage.

## Interface
- `N`, 4: number of enemy slots in the formation, 1..16
- `X_START`, 64: formation left x after spawn
- `Y_START`, 48: formation top y after spawn
- `SPACING`, 48: x pitch between slots
- `EN_W`, 32: enemy box width
- `EN_H`, 24: enemy box height
- `X_MIN`, 16: left bound for the formation
- `X_MAX`, 784: right bound for the formation
- `DROP`, 16: y step at each direction reversal
- `Y_LIMIT`, 520: formation y at or above which `wave_landed` is raised
- `M_SPEED`, 4: enemy missile y step per frame
- `SCREEN_H`, 600: missile is retired at or beyond this y

Ports:
- `pclk` in 1: pixel clock
- `rst` in 1: asynchronous, active-high reset
- `vcount_in`, `hcount_in` in 11: pixel counters
- `vsync_in`, `vblnk_in`, `hsync_in`, `hblnk_in` in 1: timing
- `rgb_in` in 12: upstream colour
- `level` in 5: difficulty
- `start` in 1: one-cycle pulse that (re)spawns the wave
- `xpos_missile`, `ypos_missile` in 11: player missile tip
- `on_missile` in 1: player missile active
- `vcount_out`, `hcount_out` out 11: delayed counters
- `vsync_out`, `vblnk_out`, `hsync_out`, `hblnk_out` out 1: delayed timing
- `rgb_out` out 12: composited colour
- `alive` out N: per-slot alive mask
- `kill` out 1: one-cycle pulse per enemy destroyed
- `hit_slot` out 4: index of the last slot destroyed
- `wave_clear` out 1: level signal, set when `alive == 0` in RUN
- `wave_landed` out 1: level signal, set when the formation reaches `Y_LIMIT`
- `xpos_en_missile`, `ypos_en_missile` out 11: enemy missile position
- `on_en_missile` out 1: enemy missile active

## Operation
- **Frame tick:** one-cycle pulse on the rising edge of `vblnk_in`, registered. All motion and firing updates happen only on the tick.
- **FSM states:**
  - IDLE → SPAWN on `start`.
  - SPAWN: `alive` = all ones, base = (`X_START`, `Y_START`), dir = right, missile off. Goes to RUN on the next cycle.
  - RUN → CLEAR when `alive == 0`.
  - RUN → LANDED when base y ≥ `Y_LIMIT`.
  - CLEAR and LANDED hold until `start`, which goes to SPAWN. A `start` pulse in any state goes to SPAWN.
- **Motion (RUN, on tick):**
  - step = 1 + `level[4:2]`, range 1..8.
  - Right edge = base x + (N−1)·`SPACING` + `EN_W`.
  - If the next step would pass `X_MAX` (moving right) or `X_MIN` (moving left): x is unchanged, y += `DROP`, dir flips. Otherwise x ± step.
  - All arithmetic is 11-bit unsigned. Bounds are checked before the update, so wrap-around never occurs.
- **Collision (RUN, every cycle):**
  - Slot i is hit when `alive[i]`, `on_missile`, and the missile tip lies within [xi, xi+`EN_W`) × [y, y+`EN_H`).
  - On a hit, the bit is cleared and `kill` is pulsed. If several slots are hit in the same cycle, only the lowest index is cleared that cycle.
- **Enemy missile (RUN, on tick):**
  - If the missile is off and an alive slot exists: scan from `rr_ptr` upward with wrap to find the first alive slot. Spawn at (slot centre x, base y + `EN_H`), set on, and set `rr_ptr` = slot+1 mod N.
  - If the missile is on: y += `M_SPEED`. When y ≥ `SCREEN_H`, it goes off.
  - A missile already in flight continues after its shooter dies.
- **Drawing:**
  - Pixel in an alive enemy box → 12'hF_0_0.
  - Pixel in the 2×8 missile box at the missile position → 12'hF_F_0.
  - Otherwise `rgb_in`. Enemy colour has priority over missile colour.
- **Reset:**
  - Every output is 0: counters, timing, `rgb_out`, `alive`, `kill`, `hit_slot`, flags and missile outputs.
  - FSM = IDLE, `rr_ptr` = 0, dir = right.
  - Asynchronous reset mid-frame aborts all state immediately.

## Timing
- Pixel path latency is exactly 2 `pclk` cycles for all timing signals and `rgb_out`.
  - Stage 1 registers the box hits.
  - Stage 2 registers the colour mux.
- Collision latency: `alive` bit clears and `kill` pulses 1 cycle after the qualifying input cycle.
- Formation and missile positions update 1 cycle after the tick. They are stable for the rest of the frame.
- `wave_clear` and `wave_landed` rise 1 cycle after the FSM enters CLEAR or LANDED.

## Configuration
- `EN_WAVE_MISSILE_EN` defined: the enemy missile logic, its outputs and its draw layer are present.
- Not defined:
  - `on_en_missile`, `xpos_en_missile` and `ypos_en_missile` are tied to 0.
  - `rr_ptr` is removed.
  - Only enemies are drawn; latency is unchanged.

## Structure
- Package `en_pkg` holds:
  - colour constants `EN_COLOR` and `EN_MISSILE_COLOR`;
  - the FSM state encoding (IDLE, SPAWN, RUN, CLEAR, LANDED);
  - the missile box size.
- Sub-module `en_wave_draw` holds the 2-stage pixel pipeline. It takes base x/y, `alive` and missile position/on.
- The FSM, motion, collision and missile logic stay in `en_wave`.

## Test plan
- Reset asserted mid-frame, then `start` → all outputs 0 during reset; `alive` = 4'b1111 two cycles after `start`; base (64,48).
- `level` = 0, 10 ticks → base x = 74. With `level` = 5'b11100 → step 8 per tick.
- Run to the right bound → at the first tick where x+3·48+32+step > 784: x is held, y = 64, dir = left.
- Player missile at (70,50) `on_missile`=1 → `alive` = 4'b1110, one `kill` pulse, `hit_slot` = 0. The same missile overlapping slots 1 and 2 → only slot 1 is cleared.
- `alive` = 4'b0101, `rr_ptr` = 1 → the missile spawns from slot 2, then from slot 0. It goes off when y ≥ 600. Killing all → `wave_clear` = 1.
- Pixel-chain check → `rgb_out`/`hsync_out` equal the inputs delayed 2 cycles outside sprites; red inside an alive box; yellow on the missile. With `EN_WAVE_MISSILE_EN` undefined → `on_en_missile` stays 0.
